fir_avmm_agent: RTL and testbench

Avalon-MM agent (responder) that terminates the `mm_bridge_0_m0` master exported by the Nios subsystem. It exposes the FIR datapath to software through:
- a control/status register bank;
- a 16-entry coefficient bank;
- an input-sample FIFO that software writes;
- an output-result FIFO that software reads.

It sits in the FPGA top level between the Qsys bridge and the FIR core. The FIR core talks to it over valid/ready streams and a registered coefficient read port.

---
 rtl/fir_avmm_agent_if.sv | 45 ++++
 rtl/fir_avmm_agent.sv | 216 +++++++++++++++++++++
 tb/tb_fir_avmm_agent.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_avmm_agent_if.sv
// ----------------------------------------------------------------------------
// fir_avmm_agent_if
//   Avalon-MM bus from the Qsys bridge master (mm_bridge_0_m0) to the FIR
//   agent. It carries 32-bit data and a 10-bit word address.
//
//   master modport : bridge side. It drives the request and sees the stall and
//                    the response.
//   slave  modport : agent side. It sees the request and drives the stall and
//                    the response.
//
//   avs_address        word address
//   avs_read           read request
//   avs_write          write request
//   avs_writedata      write data
//   avs_byteenable     byte lanes
//   avs_burstcount     always 1; the agent ignores it
//   avs_debugaccess    the agent ignores it
//   avs_waitrequest    stall (write path only)
//   avs_readdata       read data, fixed latency 1
//   avs_readdatavalid  read response strobe
// ----------------------------------------------------------------------------
interface fir_avmm_agent_if;
  logic [9:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_burstcount;
  logic        avs_debugaccess;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
           avs_burstcount, avs_debugaccess,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
           avs_burstcount, avs_debugaccess,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/fir_avmm_agent.sv
// ----------------------------------------------------------------------------
// fir_avmm_agent
//   Avalon-MM responder that exposes the FIR datapath to software. It holds a
//   CTRL/STATUS register pair, a coefficient bank, an input-sample FIFO that
//   software fills, and an output-result FIFO that software drains.
//
//   Ports:
//     clk_clk, reset_reset_n    system clock, async active-low reset
//     avs                       Avalon-MM slave (see fir_avmm_agent_if)
//     smp_data/valid/ready      sample stream toward the FIR core
//     res_data/valid/ready      result stream from the FIR core
//     coef_rd_addr/coef_rd_data registered coefficient read port (latency 1)
//     fir_enable                CTRL.enable
//     fir_clear                 one-cycle pulse after a CTRL.clear write
//
//   Word address map:
//     0x000 CTRL    0x001 STATUS    0x002 SAMPLE_IN    0x003 RESULT_OUT
//     0x004 ID      0x100.. COEF[0..NUM_COEF-1]
// ----------------------------------------------------------------------------
module fir_avmm_agent #(
  parameter int NUM_COEF   = 16,
  parameter int COEF_W     = 16,
  parameter int SMP_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  fir_avmm_agent_if.slave     avs,
  output logic [SMP_W-1:0]    smp_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  input  logic [31:0]         res_data,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [3:0]          coef_rd_addr,
  output logic [COEF_W-1:0]   coef_rd_data,
  output logic                fir_enable,
  output logic                fir_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NUM_COEF);

  localparam logic [9:0]  ADDR_CTRL   = 10'h000;
  localparam logic [9:0]  ADDR_STATUS = 10'h001;
  localparam logic [9:0]  ADDR_SAMPLE = 10'h002;
  localparam logic [9:0]  ADDR_RESULT = 10'h003;
  localparam logic [9:0]  ADDR_ID     = 10'h004;
  localparam logic [9:0]  ADDR_COEF   = 10'h100;
  localparam logic [31:0] ID_VALUE    = 32'hF1B0_0001;

  // FIFO state
  logic [SMP_W-1:0] in_mem  [FIFO_DEPTH];
  logic [31:0]      out_mem [FIFO_DEPTH];
  logic [AW-1:0]    in_wr, in_rd, out_wr, out_rd;
  logic [LW-1:0]    in_count, out_count;
  logic             in_full, in_empty, out_full, out_empty;
  logic             in_push, in_pop, out_push, out_pop;

  // Register state
  logic [COEF_W-1:0] coef [NUM_COEF];
  logic              underflow;

  // Bus decode
  logic              wr_acc, rd_acc, clear_req, is_coef;
  logic [CW-1:0]     coef_idx;
  logic [15:0]       be_mask;
  logic [31:0]       status_word, rd_mux;

  assign in_full   = (in_count == LW'(FIFO_DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_full  = (out_count == LW'(FIFO_DEPTH));
  assign out_empty = (out_count == '0);

  // The stall looks only at the registered in_full. A pop by the FIR core in
  // the same cycle frees a slot, but the write completes one cycle later.
  assign avs.avs_waitrequest = avs.avs_write && (avs.avs_address == ADDR_SAMPLE) && in_full;
  assign wr_acc    = avs.avs_write && !avs.avs_waitrequest;
  // A write in the same cycle wins, and the read is dropped with no response.
  assign rd_acc    = avs.avs_read && !avs.avs_write;
  assign clear_req = wr_acc && (avs.avs_address == ADDR_CTRL) && avs.avs_writedata[1];

  assign is_coef  = (avs.avs_address >= ADDR_COEF) &&
                    (avs.avs_address <  ADDR_COEF + 10'(NUM_COEF));
  assign coef_idx = avs.avs_address[CW-1:0];
  assign be_mask  = {{8{avs.avs_byteenable[1]}}, {8{avs.avs_byteenable[0]}}};

  // Streams. smp_data is forced to 0 while the FIFO is empty so it never
  // shows stale or uninitialised storage.
  assign smp_valid = !in_empty;
  assign smp_data  = in_empty ? '0 : in_mem[in_rd];
  assign res_ready = !out_full;

  assign in_push  = wr_acc && (avs.avs_address == ADDR_SAMPLE);
  assign in_pop   = smp_valid && smp_ready;
  assign out_push = res_valid && res_ready;
  assign out_pop  = rd_acc && (avs.avs_address == ADDR_RESULT) && !out_empty;

  // Bus inputs that carry no meaning for this agent.
  logic unused_ok;
  assign unused_ok = &{1'b0, avs.avs_burstcount, avs.avs_debugaccess,
                       avs.avs_byteenable[3:2], avs.avs_writedata[31:16]};

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: FIFO storage has no reset. The pointers and counts define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_clk) begin
    if (in_push)  in_mem[in_wr]   <= avs.avs_writedata[SMP_W-1:0];
    if (out_push) out_mem[out_wr] <= res_data;
  end

  // NOTE: all state below uses non-blocking assignments. Every flop then
  // samples pre-edge values, so process ordering cannot change the result.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else if (clear_req) begin
      // A clear overrides any push or pop in the same cycle.
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (in_push)  in_wr  <= in_wr  + AW'(1);
      if (in_pop)   in_rd  <= in_rd  + AW'(1);
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop)  out_rd <= out_rd + AW'(1);
      in_count  <= in_count  + LW'(in_push)  - LW'(in_pop);
      out_count <= out_count + LW'(out_push) - LW'(out_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // CTRL, underflow flag, clear pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fir_enable <= 1'b0;
      fir_clear  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      fir_clear <= clear_req;
      if (wr_acc && (avs.avs_address == ADDR_CTRL)) begin
        fir_enable <= avs.avs_writedata[0];
        if (avs.avs_writedata[2]) underflow <= 1'b0;
      end else if (rd_acc && (avs.avs_address == ADDR_RESULT) && out_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient bank and its registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= '0;
      coef_rd_data <= '0;
    end else begin
      if (wr_acc && is_coef)
        coef[coef_idx] <= (coef[coef_idx] & ~be_mask[COEF_W-1:0]) |
                          (avs.avs_writedata[COEF_W-1:0] & be_mask[COEF_W-1:0]);
      // The read sees the pre-edge array, so a bus write to the same index in
      // the same cycle returns the old value.
      coef_rd_data <= (32'(coef_rd_addr) < 32'(NUM_COEF)) ? coef[coef_rd_addr[CW-1:0]] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. The mux uses pre-edge state and is registered for latency 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    status_word         = '0;
    status_word[0]      = in_full;
    status_word[1]      = in_empty;
    status_word[2]      = out_full;
    status_word[3]      = out_empty;
    status_word[4]      = underflow;
    status_word[11:8]   = 4'(in_count);
    status_word[19:16]  = 4'(out_count);
  end

  // NOTE: rd_mux receives a default before the case. That default keeps an
  // unlisted address from inferring a latch.
  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      ADDR_CTRL:   rd_mux = {31'b0, fir_enable};
      ADDR_STATUS: rd_mux = status_word;
      ADDR_RESULT: rd_mux = out_empty ? '0 : out_mem[out_rd];
      ADDR_ID:     rd_mux = ID_VALUE;
      default:     if (is_coef) rd_mux = 32'(coef[coef_idx]);
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.avs_readdatavalid <= 1'b0;
      avs.avs_readdata      <= '0;
    end else begin
      avs.avs_readdatavalid <= rd_acc;
      avs.avs_readdata      <= rd_acc ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_fir_avmm_agent.sv
// ----------------------------------------------------------------------------
// tb_fir_avmm_agent
//   Directed self-checking bench for fir_avmm_agent. Every expected value
//   below is written out by hand from the register map. Inputs change on the
//   falling clock edge, and outputs are sampled there or 1 time unit later.
// ----------------------------------------------------------------------------
module tb_fir_avmm_agent;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  coef_rd_addr;
  logic [15:0] coef_rd_data;
  logic        fir_enable;
  logic        fir_clear;

  int checks = 0;
  int errors = 0;

  fir_avmm_agent_if avs_if ();

  fir_avmm_agent dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (avs_if),
    .smp_data      (smp_data),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .coef_rd_addr  (coef_rd_addr),
    .coef_rd_data  (coef_rd_data),
    .fir_enable    (fir_enable),
    .fir_clear     (fir_clear)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk_clk);
    avs_if.avs_read    = 1'b1;
    avs_if.avs_address = addr;
    @(negedge clk_clk);
    avs_if.avs_read    = 1'b0;
    check({tag, ".valid"}, 32'(avs_if.avs_readdatavalid), 32'd1);
    check(tag, avs_if.avs_readdata, exp);
  endtask

  // Returns the number of stalled cycles. A bounded wait is reported as a failure.
  task automatic bus_write(input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output int stalls);
    @(negedge clk_clk);
    avs_if.avs_write      = 1'b1;
    avs_if.avs_address    = addr;
    avs_if.avs_writedata  = data;
    avs_if.avs_byteenable = be;
    stalls = 0;
    #1;
    while (avs_if.avs_waitrequest && stalls < 100) begin
      @(negedge clk_clk);
      #1;
      stalls++;
    end
    if (stalls >= 100) check("write.timeout", 32'(stalls), 32'd0);
    @(negedge clk_clk);
    avs_if.avs_write = 1'b0;
  endtask

  initial begin
    int st;

    reset_reset_n          = 1'b0;
    avs_if.avs_address     = '0;
    avs_if.avs_read        = 1'b0;
    avs_if.avs_write       = 1'b0;
    avs_if.avs_writedata   = '0;
    avs_if.avs_byteenable  = 4'hF;
    avs_if.avs_burstcount  = 1'b1;
    avs_if.avs_debugaccess = 1'b0;
    smp_ready    = 1'b0;
    res_data     = '0;
    res_valid    = 1'b0;
    coef_rd_addr = '0;

    // ---- reset values ----
    #12;
    check("rst.waitrequest", 32'(avs_if.avs_waitrequest), 32'd0);
    check("rst.readdata", avs_if.avs_readdata, 32'd0);
    check("rst.readdatavalid", 32'(avs_if.avs_readdatavalid), 32'd0);
    check("rst.smp_valid", 32'(smp_valid), 32'd0);
    check("rst.smp_data", 32'(smp_data), 32'd0);
    check("rst.res_ready", 32'(res_ready), 32'd1);
    check("rst.coef_rd_data", 32'(coef_rd_data), 32'd0);
    check("rst.fir_enable", 32'(fir_enable), 32'd0);
    check("rst.fir_clear", 32'(fir_clear), 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // ---- ID and STATUS ----
    bus_read(10'h004, 32'hF1B0_0001, "id");
    @(negedge clk_clk);
    check("id.single_valid", 32'(avs_if.avs_readdatavalid), 32'd0);
    bus_read(10'h001, 32'h0000_000A, "status.idle");
    bus_read(10'h000, 32'h0, "ctrl.reset");
    bus_read(10'h002, 32'h0, "sample_in.read");
    bus_read(10'h005, 32'h0, "unmapped.005");
    bus_read(10'h110, 32'h0, "unmapped.110");

    // ---- coefficients ----
    bus_write(10'h103, 32'h1234_ABCD, 4'b0001, st);
    bus_read(10'h103, 32'h0000_00CD, "coef3.be0");
    coef_rd_addr = 4'd3;
    #1 check("coef_rd.latency_old", 32'(coef_rd_data), 32'd0);
    @(negedge clk_clk);
    check("coef_rd.3", 32'(coef_rd_data), 32'h0000_00CD);
    bus_write(10'h103, 32'h0000_5555, 4'b0011, st);
    check("coef_rd.same_cycle_old", 32'(coef_rd_data), 32'h0000_00CD);
    @(negedge clk_clk);
    check("coef_rd.new", 32'(coef_rd_data), 32'h0000_5555);
    bus_read(10'h103, 32'h0000_5555, "coef3.be01");

    // ---- input FIFO fill, stall, drain ----
    for (int i = 1; i <= 8; i++) begin
      bus_write(10'h002, 32'(i), 4'hF, st);
      check($sformatf("sample%0d.stalls", i), 32'(st), 32'd0);
    end
    check("in.head1.valid", 32'(smp_valid), 32'd1);
    check("in.head1.data", 32'(smp_data), 32'd1);
    bus_read(10'h001, 32'h0000_0809, "status.in_full");

    @(negedge clk_clk);
    avs_if.avs_write     = 1'b1;
    avs_if.avs_address   = 10'h002;
    avs_if.avs_writedata = 32'd9;
    #1 check("sample9.stall0", 32'(avs_if.avs_waitrequest), 32'd1);
    @(negedge clk_clk);
    check("sample9.stall1", 32'(avs_if.avs_waitrequest), 32'd1);
    smp_ready = 1'b1;
    #1 check("sample9.stall_on_pop", 32'(avs_if.avs_waitrequest), 32'd1);
    @(negedge clk_clk);
    smp_ready = 1'b0;
    check("sample9.released", 32'(avs_if.avs_waitrequest), 32'd0);
    check("in.head2", 32'(smp_data), 32'd2);
    @(negedge clk_clk);
    avs_if.avs_write = 1'b0;
    bus_read(10'h001, 32'h0000_0809, "status.in_full2");

    smp_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("drain%0d.valid", k), 32'(smp_valid), 32'd1);
      check($sformatf("drain%0d.data", k), 32'(smp_data), 32'(k));
      @(negedge clk_clk);
    end
    check("drain.empty", 32'(smp_valid), 32'd0);
    smp_ready = 1'b0;

    // ---- output FIFO fill, read, underflow ----
    @(negedge clk_clk);
    for (int i = 0; i < 9; i++) begin
      res_valid = 1'b1;
      res_data  = 32'h0000_00A0 + 32'(i);
      #1 check($sformatf("res_ready%0d", i), 32'(res_ready), 32'(i < 8));
      @(negedge clk_clk);
    end
    bus_read(10'h001, 32'h0008_0006, "status.out_full");
    bus_read(10'h003, 32'h0000_00A0, "result0");
    check("res_ready.after_pop", 32'(res_ready), 32'd1);
    @(negedge clk_clk);
    check("res_ready.refull", 32'(res_ready), 32'd0);
    res_valid = 1'b0;
    for (int k = 1; k <= 8; k++)
      bus_read(10'h003, 32'h0000_00A0 + 32'(k), $sformatf("result%0d", k));
    bus_read(10'h003, 32'h0, "result.empty");
    bus_read(10'h001, 32'h0000_001A, "status.underflow");
    bus_write(10'h000, 32'h4, 4'hF, st);
    bus_read(10'h001, 32'h0000_000A, "status.underflow_cleared");

    // ---- CTRL.clear ----
    bus_write(10'h002, 32'h11, 4'hF, st);
    bus_write(10'h002, 32'h22, 4'hF, st);
    bus_write(10'h002, 32'h33, 4'hF, st);
    @(negedge clk_clk);
    res_valid = 1'b1;
    res_data  = 32'h55;
    @(negedge clk_clk);
    res_valid = 1'b0;
    check("pre_clear.head", 32'(smp_data), 32'h11);
    bus_read(10'h001, 32'h0001_0300, "status.pre_clear");
    @(negedge clk_clk);
    avs_if.avs_write     = 1'b1;
    avs_if.avs_address   = 10'h000;
    avs_if.avs_writedata = 32'h3;
    @(negedge clk_clk);
    avs_if.avs_write = 1'b0;
    check("clear.enable", 32'(fir_enable), 32'd1);
    check("clear.pulse", 32'(fir_clear), 32'd1);
    check("clear.smp_valid", 32'(smp_valid), 32'd0);
    @(negedge clk_clk);
    check("clear.pulse_end", 32'(fir_clear), 32'd0);
    bus_read(10'h001, 32'h0000_000A, "status.post_clear");
    bus_read(10'h000, 32'h0000_0001, "ctrl.enable_only");

    // ---- reset during an accepted read ----
    bus_write(10'h105, 32'h0000_BEEF, 4'b0011, st);
    bus_write(10'h002, 32'h77, 4'hF, st);
    coef_rd_addr = 4'd5;
    @(negedge clk_clk);
    check("pre_rst.coef_rd", 32'(coef_rd_data), 32'h0000_BEEF);
    check("pre_rst.smp_valid", 32'(smp_valid), 32'd1);
    @(negedge clk_clk);
    avs_if.avs_read    = 1'b1;
    avs_if.avs_address = 10'h004;
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b0;
    #1;
    avs_if.avs_read = 1'b0;
    check("mid_rst.readdatavalid", 32'(avs_if.avs_readdatavalid), 32'd0);
    check("mid_rst.readdata", avs_if.avs_readdata, 32'd0);
    check("mid_rst.fir_enable", 32'(fir_enable), 32'd0);
    check("mid_rst.smp_valid", 32'(smp_valid), 32'd0);
    check("mid_rst.smp_data", 32'(smp_data), 32'd0);
    check("mid_rst.res_ready", 32'(res_ready), 32'd1);
    check("mid_rst.coef_rd", 32'(coef_rd_data), 32'd0);
    check("mid_rst.fir_clear", 32'(fir_clear), 32'd0);
    check("mid_rst.waitrequest", 32'(avs_if.avs_waitrequest), 32'd0);
    @(posedge clk_clk);
    @(negedge clk_clk);
    check("rst_hold.readdatavalid", 32'(avs_if.avs_readdatavalid), 32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("post_rst.readdatavalid", 32'(avs_if.avs_readdatavalid), 32'd0);
    check("post_rst.coef_rd", 32'(coef_rd_data), 32'd0);
    bus_read(10'h105, 32'h0, "post_rst.coef5");
    bus_read(10'h001, 32'h0000_000A, "post_rst.status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
